// File: rtl/sr_ext_cbrt_sqrt.sv
// Multicycle ALU_EXT unit: y = floor(cbrt(a[7:0])) + floor(sqrt(b[7:0])).
// Fixed 7-cycle latency start/busy responder with a zero-extended result.
module sr_ext_cbrt_sqrt #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] srcA,
  input  logic [DATA_W-1:0] srcB,
  output logic              busy,
  output logic [DATA_W-1:0] result
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CB_B   = 2'd1,
    CB_CMP = 2'd2,
    SUM    = 2'd3
  } st_t;

  st_t         r_st;
  st_t         w_nxt;
  logic [7:0]  r_xa;
  logic [7:0]  r_xb;
  logic [7:0]  r_ys;
  logic [7:0]  r_m;
  logic [2:0]  r_yc;
  logic [2:0]  r_s;
  logic [10:0] r_bc;
  logic        r_busy;
  logic [4:0]  r_res;

  logic        w_lat;
  logic        w_cbb;
  logic        w_cmp;
  logic        w_sum;
  logic        w_sq;
  logic [3:0]  w_y2;
  logic [10:0] w_y2x;
  logic [10:0] w_poly;
  logic [10:0] w_bcn;
  logic [7:0]  w_t;
  logic [7:0]  w_ysh;
  logic        w_unused;

  assign w_unused = ^{srcA[DATA_W-1:8], srcB[DATA_W-1:8]};

  // state register
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) r_st <= IDLE;
    else        r_st <= w_nxt;
  end

  // next-state logic
  always_comb begin
    w_nxt = r_st;
    unique case (r_st)
      IDLE:    if (start) w_nxt = CB_B;
      CB_B:    w_nxt = CB_CMP;
      CB_CMP:  w_nxt = (r_s == 3'd0) ? SUM : CB_B;
      SUM:     w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // output / strobe decode
  always_comb begin
    w_lat = 1'b0;
    w_cbb = 1'b0;
    w_cmp = 1'b0;
    w_sum = 1'b0;
    unique case (1'b1)
      (r_st == IDLE):   w_lat = start;
      (r_st == CB_B):   w_cbb = 1'b1;
      (r_st == CB_CMP): w_cmp = 1'b1;
      (r_st == SUM):    w_sum = 1'b1;
      default:          w_lat = 1'b0;
    endcase
  end

  // bit-serial cube root works on the doubled partial root
  assign w_y2   = {r_yc, 1'b0};
  assign w_y2x  = {7'd0, w_y2};
  assign w_poly = 11'd3 * w_y2x * (w_y2x + 11'd1) + 11'd1;
  assign w_bcn  = w_poly << r_s;

  assign w_sq  = (r_st != IDLE) && (r_m != 8'd0);
  assign w_t   = r_ys | r_m;
  assign w_ysh = r_ys >> 1;

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_xa   <= '0;
      r_xb   <= '0;
      r_ys   <= '0;
      r_m    <= '0;
      r_yc   <= '0;
      r_s    <= '0;
      r_bc   <= '0;
      r_busy <= 1'b0;
      r_res  <= '0;
    end else begin
      r_busy <= (w_nxt != IDLE);
      if (w_lat) begin
        r_xa <= srcA[7:0];
        r_xb <= srcB[7:0];
        r_yc <= '0;
        r_ys <= '0;
        r_s  <= 3'd6;
        r_m  <= 8'h40;
      end
      if (w_cbb) begin
        r_yc <= w_y2[2:0];
        r_bc <= w_bcn;
      end
      if (w_cmp) begin
        if ({3'd0, r_xa} >= r_bc) begin
          r_xa <= r_xa - r_bc[7:0];
          r_yc <= r_yc + 3'd1;
        end
        r_s <= r_s - 3'd3;
      end
      if (w_sq) begin
        if (r_xb >= w_t) begin
          r_xb <= r_xb - w_t;
          r_ys <= w_ysh | r_m;
        end else begin
          r_ys <= w_ysh;
        end
        r_m <= r_m >> 2;
      end
      if (w_sum)
        r_res <= {2'd0, r_yc} + {1'b0, r_ys[3:0]};
    end
  end

  assign busy   = r_busy;
  assign result = {{(DATA_W-5){1'b0}}, r_res};

endmodule

// File: tb/tb_sr_ext_cbrt_sqrt.sv
// Directed bench for sr_ext_cbrt_sqrt: latency, results,
// operand latching, mid-op reset and back-to-back starts.
module tb_sr_ext_cbrt_sqrt;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic        busy;
  logic [31:0] result;

  int n_chk;
  int n_err;

  sr_ext_cbrt_sqrt #(.DATA_W(32)) dut (
    .clk_i  (clk),
    .rst_n  (rst_n),
    .start  (start),
    .srcA   (srcA),
    .srcB   (srcB),
    .busy   (busy),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // counts busy cycles after the start edge, bounded
  task automatic wait_done(output int cnt);
    cnt = 0;
    while (busy && cnt < 20) begin
      cnt++;
      tick();
    end
  endtask

  task automatic run_op(input string tag, input logic [7:0] a,
                        input logic [7:0] b, input int exp);
    int cnt;
    srcA  = {24'hABCDEF, a};
    srcB  = {24'h123456, b};
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cnt);
    chk({tag, " lat"}, cnt, 7);
    chk({tag, " res"}, result, exp);
  endtask

  typedef struct {
    string      tag;
    logic [7:0] a;
    logic [7:0] b;
    int         y;
  } vec_t;

  vec_t vecs[$] = '{
    '{"27_16",   8'd27,  8'd16,  7},
    '{"8_15",    8'd8,   8'd15,  5},
    '{"0_0",     8'd0,   8'd0,   0},
    '{"1_1",     8'd1,   8'd1,   2},
    '{"7_3",     8'd7,   8'd3,   2},
    '{"26_8",    8'd26,  8'd8,   4},
    '{"63_63",   8'd63,  8'd63,  10},
    '{"64_64",   8'd64,  8'd64,  12},
    '{"124_143", 8'd124, 8'd143, 15},
    '{"128_0",   8'd128, 8'd0,   5},
    '{"0_100",   8'd0,   8'd100, 10},
    '{"200_200", 8'd200, 8'd200, 19},
    '{"216_225", 8'd216, 8'd225, 21},
    '{"255_255", 8'd255, 8'd255, 21}
  };

  initial begin
    int cnt;
    int idle;
    int falls;
    n_chk = 0;
    n_err = 0;
    rst_n = 1'b0;
    start = 1'b0;
    srcA  = '0;
    srcB  = '0;
    #12;
    chk("rst busy", {31'd0, busy}, 0);
    chk("rst res", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (busy) cnt++;
    end
    chk("idle busy", cnt, 0);

    foreach (vecs[i]) run_op(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].y);

    // operands and start ignored while busy
    srcA  = 32'd64;
    srcB  = 32'd81;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("lat busy0", {31'd0, busy}, 1);
    chk("lat hold", result, 21);
    tick();
    tick();
    srcA  = 32'd1;
    srcB  = 32'd1;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(cnt);
    chk("lat cyc", cnt, 4);
    chk("lat res", result, 13);
    tick();
    chk("lat no2nd", {31'd0, busy}, 0);

    // reset in the middle of an op
    srcA  = 32'd125;
    srcB  = 32'd49;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort busy", {31'd0, busy}, 0);
    chk("abort res", result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tick();
    chk("post busy", {31'd0, busy}, 0);
    chk("post res", result, 0);
    run_op("1_4", 8'd1, 8'd4, 3);

    // start held high: back-to-back ops, one idle cycle apart
    srcA  = 32'd27;
    srcB  = 32'd9;
    start = 1'b1;
    falls = 0;
    tick();
    wait_done(cnt);
    chk("b2b lat1", cnt, 7);
    chk("b2b res1", result, 6);
    falls++;
    idle = 0;
    while (!busy && idle < 5) begin
      idle++;
      tick();
    end
    start = 1'b0;
    chk("b2b idle", idle, 1);
    wait_done(cnt);
    chk("b2b lat2", cnt, 7);
    chk("b2b res2", result, 6);
    falls++;
    tick();
    tick();
    if (busy) falls++;
    chk("b2b ops", falls, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
